// File: rtl/lr35902_oam_pkg.sv
// Shared sizes, open-bus constants and storage request type for the OAM responder.
package lr35902_oam_pkg;

  localparam logic [7:0]  OAM_BYTES     = 8'd160;
  localparam logic [6:0]  OAM_WORDS     = 7'd80;
  localparam logic [7:0]  OAM_OPEN_BUS  = 8'hff;
  localparam logic [15:0] OAM_OPEN_WORD = 16'hffff;

  // One storage access per cycle; the arbiter fills exactly one of these.
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        re;
  } oam_req_t;

  // Byte lane enable for a byte address whose LSB picks the high (X) byte.
  function automatic logic [1:0] lane_en(input logic hi);
    return hi ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/lr35902_oam_ram.sv
// 80x16 single-port synchronous sprite RAM with byte enables and registered read.
module lr35902_oam_ram
  import lr35902_oam_pkg::*;
(
  input  logic        clk,
  input  logic [6:0]  addr,
  input  logic [1:0]  be,
  input  logic [15:0] wdata,
  input  logic        re,
  output logic [15:0] rdata
);

  logic [15:0] mem [0:OAM_WORDS-1];

  // NOTE: storage and read register are deliberately not reset, so contents survive reset and map to plain RAM.
  always_ff @(posedge clk) begin
    if (addr < OAM_WORDS) begin
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
    end
    if (re) rdata <= (addr < OAM_WORDS) ? mem[addr] : OAM_OPEN_WORD;
  end

endmodule

// File: rtl/lr35902_oam.sv
// OAM responder: arbitrates DMA > PPU > CPU onto the sprite RAM and returns open-bus data on refusal.
// Define LR35902_OAM_PPU_LOCK_EN to also lock the CPU out while ppu_busy is high.
module lr35902_oam
  import lr35902_oam_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  dma_adr,
  input  logic [7:0]  dma_din,
  input  logic        dma_write,
  input  logic        dma_active,
  input  logic [7:0]  cpu_adr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [7:0]  cpu_dout,
  output logic        cpu_blocked,
  input  logic [6:0]  ppu_adr,
  input  logic        ppu_read,
  input  logic        ppu_busy,
  output logic [15:0] ppu_dout,
  output logic        ppu_valid
);

  logic        dma_wr_ok;
  logic        cpu_strobe;
  logic        cpu_in_range;
  logic        cpu_lock;
  logic        cpu_grant;
  logic        cpu_rd_grant;
  logic        ppu_grant;
  oam_req_t    req;
  logic [15:0] rdata;

  logic        cpu_pend;
  logic        cpu_pend_hi;
  logic [7:0]  cpu_hold;
  logic        ppu_pend;
  logic [15:0] ppu_hold;

`ifdef LR35902_OAM_PPU_LOCK_EN
  assign cpu_lock = ppu_busy;
`else
  logic unused_ppu_busy;
  assign unused_ppu_busy = ppu_busy;
  assign cpu_lock        = 1'b0;
`endif

  assign dma_wr_ok    = dma_write && (dma_adr < OAM_BYTES);
  assign ppu_grant    = ppu_read && !dma_write;
  assign cpu_strobe   = cpu_read || cpu_write;
  assign cpu_in_range = cpu_adr < OAM_BYTES;
  assign cpu_grant    = cpu_strobe && cpu_in_range && !dma_active && !dma_write
                        && !ppu_read && !cpu_lock;
  assign cpu_rd_grant = cpu_grant && !cpu_write;

  // An out-of-range DMA write still owns the cycle; it just enables no byte lane.
  always_comb begin
    // NOTE: default every field first so no branch leaves req unassigned and infers a latch.
    req = '0;
    if (dma_write) begin
      req.addr  = dma_adr[7:1];
      req.be    = dma_wr_ok ? lane_en(dma_adr[0]) : 2'b00;
      req.wdata = {dma_din, dma_din};
    end else if (ppu_read) begin
      req.addr = ppu_adr;
      req.re   = 1'b1;
    end else if (cpu_grant) begin
      req.addr  = cpu_adr[7:1];
      req.be    = cpu_write ? lane_en(cpu_adr[0]) : 2'b00;
      req.wdata = {cpu_din, cpu_din};
      req.re    = !cpu_write;
    end
  end

  lr35902_oam_ram u_ram (
    .clk   (clk),
    .addr  (req.addr),
    .be    (req.be),
    .wdata (req.wdata),
    .re    (req.re),
    .rdata (rdata)
  );

  // RAM read data is shared, so each requester captures its word into a hold register one cycle later.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values, so later
  // statements here only override earlier ones and never see their results.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_pend    <= 1'b0;
      cpu_pend_hi <= 1'b0;
      cpu_hold    <= OAM_OPEN_BUS;
      cpu_blocked <= 1'b0;
      ppu_pend    <= 1'b0;
      ppu_hold    <= 16'h0000;
      ppu_valid   <= 1'b0;
    end else begin
      cpu_pend    <= cpu_rd_grant;
      cpu_pend_hi <= cpu_adr[0];
      ppu_pend    <= ppu_grant;
      ppu_valid   <= ppu_read;
      if (cpu_pend) cpu_hold <= lane_sel(rdata, cpu_pend_hi);
      if (ppu_pend) ppu_hold <= rdata;
      if (cpu_read && !cpu_write && !cpu_rd_grant) cpu_hold <= OAM_OPEN_BUS;
      if (ppu_read && dma_write) ppu_hold <= OAM_OPEN_WORD;
      if (cpu_strobe && cpu_in_range) cpu_blocked <= !cpu_grant;
    end
  end

  assign cpu_dout = cpu_pend ? lane_sel(rdata, cpu_pend_hi) : cpu_hold;
  assign ppu_dout = ppu_pend ? rdata : ppu_hold;

endmodule

// File: tb/tb_lr35902_oam.sv
// Directed plus random bench for lr35902_oam against a byte-array reference model.
module tb_lr35902_oam;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  dma_adr, dma_din;
  logic        dma_write, dma_active;
  logic [7:0]  cpu_adr, cpu_din;
  logic        cpu_read, cpu_write;
  logic [7:0]  cpu_dout;
  logic        cpu_blocked;
  logic [6:0]  ppu_adr;
  logic        ppu_read, ppu_busy;
  logic [15:0] ppu_dout;
  logic        ppu_valid;

  always #5 clk = ~clk;

  lr35902_oam dut (
    .clk         (clk),
    .reset       (reset),
    .dma_adr     (dma_adr),
    .dma_din     (dma_din),
    .dma_write   (dma_write),
    .dma_active  (dma_active),
    .cpu_adr     (cpu_adr),
    .cpu_din     (cpu_din),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_dout    (cpu_dout),
    .cpu_blocked (cpu_blocked),
    .ppu_adr     (ppu_adr),
    .ppu_read    (ppu_read),
    .ppu_busy    (ppu_busy),
    .ppu_dout    (ppu_dout),
    .ppu_valid   (ppu_valid)
  );

  // Reference model: OAM as 160 bytes plus the expected visible outputs.
  logic [7:0]  m [0:159];
  logic [7:0]  exp_cpu;
  logic        exp_blk;
  logic [15:0] exp_ppu;
  logic        exp_valid;
  logic        lock_on;
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, want);
  endtask

  task automatic idle();
    dma_write  = 1'b0;
    dma_active = 1'b0;
    cpu_read   = 1'b0;
    cpu_write  = 1'b0;
    ppu_read   = 1'b0;
    ppu_busy   = 1'b0;
  endtask

  // Predict this cycle from the rules, clock once, then compare all outputs.
  task automatic step();
    logic       ok;
    logic [7:0] pi;
    if (reset) begin
      exp_cpu   = 8'hff;
      exp_ppu   = 16'h0000;
      exp_valid = 1'b0;
      exp_blk   = 1'b0;
    end else begin
      pi        = {ppu_adr, 1'b0};
      exp_valid = ppu_read;
      if (ppu_read) exp_ppu = dma_write ? 16'hffff : {m[pi + 8'd1], m[pi]};
      ok = !dma_active && !dma_write && !ppu_read && (cpu_adr < 8'd160) && !(lock_on && ppu_busy);
      if (cpu_read && !cpu_write) exp_cpu = ok ? m[cpu_adr] : 8'hff;
      if ((cpu_read || cpu_write) && cpu_adr < 8'd160) exp_blk = !ok;
      if (dma_write && dma_adr < 8'd160) m[dma_adr] = dma_din;
      if (cpu_write && ok) m[cpu_adr] = cpu_din;
    end
    @(posedge clk);
    #1;
    check("cpu_dout",    {8'h00, cpu_dout},     {8'h00, exp_cpu});
    check("cpu_blocked", {15'h0, cpu_blocked},  {15'h0, exp_blk});
    check("ppu_valid",   {15'h0, ppu_valid},    {15'h0, exp_valid});
    check("ppu_dout",    ppu_dout,              exp_ppu);
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    idle();
    cpu_adr  = a;
    cpu_read = 1'b1;
    step();
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    idle();
    cpu_adr   = a;
    cpu_din   = d;
    cpu_write = 1'b1;
    step();
  endtask

  initial begin
`ifdef LR35902_OAM_PPU_LOCK_EN
    lock_on = 1'b1;
`else
    lock_on = 1'b0;
`endif
    idle();
    dma_adr = '0; dma_din = '0; cpu_adr = '0; cpu_din = '0; ppu_adr = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // DMA fills the table, with an ignored out-of-range write and a repeated byte
    dma_active = 1'b1;
    for (int i = 0; i < 160; i++) begin
      dma_write = 1'b1;
      dma_adr   = 8'(i);
      dma_din   = 8'(i) ^ 8'h5a;
      step();
    end
    dma_adr = 8'd7;  dma_din = 8'h07 ^ 8'h5a; step();
    dma_adr = 8'd200; dma_din = 8'h00;        step();
    idle();

    cpu_rd(8'd3);
    check("tp_dma_byte3", {8'h00, cpu_dout}, 16'h0059);
    check("tp_unblocked", {15'h0, cpu_blocked}, 16'h0000);

    // CPU lockout during DMA
    dma_active = 1'b1; cpu_adr = 8'd10; cpu_read = 1'b1; step();
    check("tp_lock_read", {8'h00, cpu_dout}, 16'h00ff);
    check("tp_lock_blk",  {15'h0, cpu_blocked}, 16'h0001);
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_din = 8'h12; step();
    cpu_rd(8'd10);
    check("tp_drop_write", {8'h00, cpu_dout}, 16'h0050);

    // CPU writes then PPU word read
    cpu_wr(8'd10, 8'h40);
    cpu_wr(8'd11, 8'h18);
    idle(); ppu_adr = 7'd5; ppu_read = 1'b1; step();
    check("tp_ppu_word5", ppu_dout, 16'h1840);
    idle(); step();
    check("tp_valid_pulse", {15'h0, ppu_valid}, 16'h0000);

    // DMA/PPU collision on word 0
    idle(); ppu_adr = 7'd0; ppu_read = 1'b1;
    dma_write = 1'b1; dma_adr = 8'd0; dma_din = 8'hc3; step();
    check("tp_collide", ppu_dout, 16'hffff);
    idle(); ppu_read = 1'b1; step();
    check("tp_after_dma", ppu_dout, 16'h5bc3);

    // Out-of-range CPU read keeps cpu_blocked
    idle(); dma_active = 1'b1; cpu_adr = 8'd4; cpu_read = 1'b1; step();
    cpu_rd(8'ha0);
    check("tp_a0_data", {8'h00, cpu_dout}, 16'h00ff);
    check("tp_a0_blk",  {15'h0, cpu_blocked}, 16'h0001);

    // ppu_busy lockout only with the macro
    idle(); ppu_busy = 1'b1; cpu_adr = 8'd3; cpu_read = 1'b1; step();
    check("tp_busy", {8'h00, cpu_dout}, lock_on ? 16'h00ff : 16'h0059);

    // Read and write together: write lands, cpu_dout holds
    cpu_rd(8'd3);
    idle(); cpu_adr = 8'd12; cpu_din = 8'h9a; cpu_read = 1'b1; cpu_write = 1'b1; step();
    check("tp_rw_hold", {8'h00, cpu_dout}, 16'h0059);
    cpu_rd(8'd12);
    check("tp_rw_write", {8'h00, cpu_dout}, 16'h009a);

    // Reset mid-access keeps storage
    cpu_wr(8'd20, 8'h77);
    cpu_rd(8'd20);
    check("tp_pre_reset", {8'h00, cpu_dout}, 16'h0077);
    idle(); cpu_adr = 8'd20; cpu_read = 1'b1; ppu_read = 1'b1; reset = 1'b1; step();
    check("tp_reset_cpu", {8'h00, cpu_dout}, 16'h00ff);
    check("tp_reset_vld", {15'h0, ppu_valid}, 16'h0000);
    reset = 1'b0;
    cpu_rd(8'd20);
    check("tp_retained", {8'h00, cpu_dout}, 16'h0077);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      dma_active = ($urandom_range(0, 3) == 0);
      dma_write  = ($urandom_range(0, 4) == 0);
      dma_adr    = 8'($urandom_range(0, 191));
      dma_din    = 8'($urandom);
      ppu_read   = ($urandom_range(0, 2) == 0);
      ppu_adr    = 7'($urandom_range(0, 79));
      ppu_busy   = ($urandom_range(0, 3) == 0);
      cpu_read   = ($urandom_range(0, 1) == 1);
      cpu_write  = ($urandom_range(0, 3) == 0);
      cpu_adr    = 8'($urandom_range(0, 175));
      cpu_din    = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lr35902_oam.md
# lr35902_oam

Object attribute memory (OAM) responder: the 160-byte sprite table and its single-port access arbiter. Terminates the write stream of the OAM DMA engine and serves CPU byte reads/writes at FE00–FE9F and PPU 16-bit sprite-scan reads. Sits in the PPU between the DMA engine, the CPU bus decoder and the sprite fetch logic; it enforces DMA and PPU priority over the CPU and returns open-bus data for blocked accesses.

## Interface
Parameters:
- none; sizes are fixed constants in the shared package.

Ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dma_adr  in  8  OAM byte address from DMA engine
- dma_din  in  8  DMA write data
- dma_write  in  1  DMA write strobe
- dma_active  in  1  DMA transfer in progress (CPU lockout)
- cpu_adr  in  8  CPU byte address (low byte of FExx)
- cpu_din  in  8  CPU write data
- cpu_read  in  1  CPU read strobe
- cpu_write  in  1  CPU write strobe
- cpu_dout  out  8  CPU read data, registered
- cpu_blocked  out  1  registered; last CPU access was refused
- ppu_adr  in  7  PPU word index (0–79); word n = bytes 2n (low, Y) and 2n+1 (high, X)
- ppu_read  in  1  PPU read strobe
- ppu_busy  in  1  PPU in mode 2 or 3
- ppu_dout  out  16  PPU read data, registered
- ppu_valid  out  1  ppu_dout updated this cycle

## Operation
- Storage: 80 words × 16 bits, byte write enables. Contents not cleared by reset.
- One storage access per cycle. Fixed priority: DMA write > PPU read > CPU access.
- DMA: dma_write with dma_adr < 160 writes dma_din to that byte. dma_adr ≥ 160 ignored. Repeated writes of the same byte on consecutive cycles are legal and idempotent.
- PPU: ppu_read always granted unless dma_write same cycle. If DMA wins: PPU word reads as 16'hffff, ppu_valid still pulses.
- CPU grant requires: dma_active low, no dma_write, no ppu_read that cycle, cpu_adr < 160, and lock condition clear (see Configuration).
- CPU read granted: cpu_dout ← byte. Refused or cpu_adr ≥ 160: cpu_dout ← 8'hff.
- CPU write granted: byte written. Refused: dropped, no side effect.
- cpu_read and cpu_write same cycle: write wins, cpu_dout unchanged.
- cpu_blocked ← 1 on any refused CPU strobe with cpu_adr < 160; ← 0 on any granted CPU strobe; held otherwise.
- Same-cycle DMA write and PPU read of same word: PPU receives 16'hffff (DMA priority), never torn data.

## Timing
- Reset values: cpu_dout 8'hff, ppu_dout 16'h0000, ppu_valid 0, cpu_blocked 0.
- Read latency 1: strobe in cycle N, data in cycle N+1. cpu_dout/ppu_dout hold until next read.
- ppu_valid single-cycle pulse in N+1 per ppu_read in N.
- Write effective at the clock edge ending cycle N; read in N+1 sees new data. Read and write to same byte in one cycle cannot occur (single grant).
- dma_active sampled combinationally; CPU lockout starts in the first cycle it is high, ends in the first cycle it is low.
- Reset mid-access: pending read discarded, outputs to reset values next edge; storage retains contents.

## Configuration
- LR35902_OAM_PPU_LOCK_EN defined: CPU additionally refused whenever ppu_busy is high (hardware-accurate mode 2/3 lockout).
- Undefined: ppu_busy ignored; CPU refused only on same-cycle collision with ppu_read, dma_write or dma_active.

## Structure
- Shared package: OAM_BYTES = 160, OAM_WORDS = 80, OAM_OPEN_BUS = 8'hff, OAM_OPEN_WORD = 16'hffff.
- Sub-module lr35902_oam_ram: 80×16 single-port synchronous RAM, 2-bit byte enable, registered read; arbiter and output muxing stay in lr35902_oam.

## Test plan
- DMA writes bytes 0..159 = i^8'h5a, then CPU reads byte 3 -> cpu_dout 8'h59 next cycle, cpu_blocked 0.
- CPU read of byte 10 with dma_active high -> cpu_dout 8'hff, cpu_blocked 1; write 8'h12 dropped, later read returns old value.
- PPU read word 5 after CPU writes bytes 10=8'h40, 11=8'h18 -> ppu_dout 16'h1840, ppu_valid pulse one cycle.
- Same cycle ppu_read word 0 and dma_write byte 0 -> ppu_dout 16'hffff; following read shows DMA byte.
- cpu_read cpu_adr 8'ha0 -> cpu_dout 8'hff, cpu_blocked unchanged; ppu_busy high with LR35902_OAM_PPU_LOCK_EN -> CPU read 8'hff, without macro -> real data.
- Assert reset after CPU read of 8'h77 -> cpu_dout 8'hff, ppu_valid 0; storage byte still reads 8'h77 afterwards.
